// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg_pkg
//  Description : Shared constants for the multiplexed BCD seven-segment
//                display path: digit count, segment patterns for 0-9,
//                the dash shown for non-decimal codes, and the blank pattern.
//                Segment bit order is seg[0]=a .. seg[6]=g, active-high.
//  Revision    : 1.0  initial release
// ============================================================================
package seg_pkg;

    localparam int unsigned N_DIGITS = 4;

    localparam logic [6:0] DASH  = 7'h40;
    localparam logic [6:0] BLANK = 7'h00;

    // Full 16-entry table so any 4-bit code indexes it directly; codes
    // 10-15 are not decimal digits and show a dash.
    localparam logic [15:0][6:0] SEG_TABLE = {
        DASH,  DASH,  DASH,  DASH,  DASH,  DASH,   // 15..10
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,         //  9..5
        7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F          //  4..0
    };

endpackage : seg_pkg
`default_nettype wire

// File: rtl/bcd_to_seg7.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_to_seg7
//  Description : Combinational BCD to seven-segment decoder. Codes 0-9 map
//                to their digit glyphs, codes 10-15 map to a dash.
//  Ports       : code  in  4  BCD code
//                seg   out 7  segments a..g, seg[0]=a, active-high
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_to_seg7
    import seg_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_TABLE[code];
    end

endmodule : bcd_to_seg7
`default_nettype wire

// File: rtl/bcd_seg_scan.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_seg_scan
//  Description : Four-digit multiplexed seven-segment scanner. A prescaler
//                sets how long each digit is enabled; a 2-bit scan index
//                walks the digits. The BCD and decimal-point inputs are
//                snapshotted once per frame so a frame never mixes old and
//                new values. Optional leading-zero blanking is applied live.
//  Ports       : clk         in  1   system clock (rising edge)
//                rst         in  1   synchronous active-high reset
//                bcd_in      in  16  four BCD digits, [3:0] = units
//                dp_in       in  4   decimal point request, bit i = digit i
//                blank_lz    in  1   leading-zero blanking enable
//                seg         out 7   segments a..g, active-high
//                dp          out 1   decimal point, active-high
//                an          out 4   digit enables, active-low
//                frame_tick  out 1   one-clock pulse after each snapshot
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_seg_scan
    import seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*N_DIGITS-1:0]   bcd_in,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [N_DIGITS-1:0]     an,
    output logic                    frame_tick
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [PW-1:0]          r_presc;
    logic [1:0]             r_idx;
    logic [1:0]             r_disp_idx;
    logic [4*N_DIGITS-1:0]  r_snap_bcd;
    logic [N_DIGITS-1:0]    r_snap_dp;
    logic                   r_tick_pend;

    logic                   w_load;
    logic                   w_wrap;
    logic [3:0]             w_code;
    logic [6:0]             w_dec_seg;
    logic                   w_blank;
    logic                   w_z3;
    logic                   w_z2;
    logic                   w_z1;

    assign w_load = (r_presc == '0) && (r_idx == 2'd0);
    assign w_wrap = (r_presc == PW'(SCAN_DIV - 1));

    // The output stage works from r_disp_idx, a one-clock-delayed copy of
    // the scan index. The snapshot loads on the first clock of digit 0, so
    // this delay keeps the new snapshot and the index aligned when digit 0
    // reaches the pins, and the frame's last digit still shows old data.
    assign w_code = r_snap_bcd[{r_disp_idx, 2'b00} +: 4];

    bcd_to_seg7 u_dec (
        .code (w_code),
        .seg  (w_dec_seg)
    );

    // A digit is a leading zero only if it and every more significant
    // digit are zero; dash codes are non-zero so they are never blanked.
    assign w_z3 = (r_snap_bcd[15:12] == 4'd0);
    assign w_z2 = w_z3 && (r_snap_bcd[11:8] == 4'd0);
    assign w_z1 = w_z2 && (r_snap_bcd[7:4]  == 4'd0);

    always_comb begin
        w_blank = 1'b0;
        case (r_disp_idx)
            2'd1:    w_blank = blank_lz && w_z1;
            2'd2:    w_blank = blank_lz && w_z2;
            2'd3:    w_blank = blank_lz && w_z3;
            default: w_blank = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc     <= '0;
            r_idx       <= 2'd0;
            r_disp_idx  <= 2'd0;
            r_snap_bcd  <= '0;
            r_snap_dp   <= '0;
            r_tick_pend <= 1'b0;
            frame_tick  <= 1'b0;
            seg         <= BLANK;
            dp          <= 1'b0;
            an          <= '1;
        end else begin
            if (w_wrap) begin
                r_presc <= '0;
                r_idx   <= r_idx + 2'd1;
            end else begin
                r_presc <= r_presc + PW'(1);
            end

            if (w_load) begin
                r_snap_bcd <= bcd_in;
                r_snap_dp  <= dp_in;
            end

            r_tick_pend <= w_load;
            r_disp_idx  <= r_idx;

            frame_tick  <= r_tick_pend;
            an          <= ~(N_DIGITS'(1) << r_disp_idx);
            seg         <= w_blank ? BLANK : w_dec_seg;
            dp          <= r_snap_dp[r_disp_idx];
        end
    end

endmodule : bcd_seg_scan
`default_nettype wire

// File: tb/tb_bcd_seg_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_seg_scan
//  Description : Self-checking bench for bcd_seg_scan with SCAN_DIV=4.
//                Expected per-digit outputs are pushed to a queue when a
//                frame's inputs are driven and popped as each digit appears.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bcd_seg_scan;

    localparam int unsigned SCAN_DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] bcd_in = 16'h0000;
    logic [3:0]  dp_in = 4'h0;
    logic        blank_lz = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_tick;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   pos    = 0;

    logic [6:0] glyph [16];

    bcd_seg_scan #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .bcd_in     (bcd_in),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        pos++;
    endtask

    task automatic advance_to(input int target);
        while (pos < target) step();
    endtask

    // Reference model: push the four digits a frame should display.
    task automatic push_frame(input logic [15:0] b, input logic [3:0] d, input logic blz);
        logic still_zero;
        logic [3:0] dig;
        exp_t e [4];
        still_zero = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            dig = b[4*i +: 4];
            e[i].an = 4'b1111;
            e[i].an[i] = 1'b0;
            e[i].dp = d[i];
            still_zero = still_zero && (dig == 4'd0);
            e[i].seg = (blz && still_zero && i != 0) ? 7'h00 : glyph[dig];
        end
        for (int i = 0; i < 4; i++) exp_q.push_back(e[i]);
    endtask

    // Runs one whole frame starting just before its snapshot edge.
    // bcd_mid is applied after digit 0 is shown and must not affect the frame.
    task automatic run_frame(input string name, input logic [15:0] b, input logic [3:0] d,
                             input logic blz, input logic [15:0] bcd_mid);
        exp_t got, want;
        pos = 0;
        bcd_in = b;
        dp_in = d;
        blank_lz = blz;
        push_frame(b, d, blz);
        for (int k = 0; k < 4; k++) begin
            advance_to(2 + 4 * k);
            got = '{an: an, seg: seg, dp: dp};
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL %s digit%0d: scoreboard empty, got an=%b seg=%h dp=%b", name, k, an, seg, dp);
            end else begin
                want = exp_q.pop_front();
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL %s digit%0d: got an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
                             name, k, got.an, got.seg, got.dp, want.an, want.seg, want.dp);
                end
            end
            if (k == 0) begin
                checks++;
                if (frame_tick !== 1'b1) begin
                    errors++;
                    $display("FAIL %s frame_tick_high: got %b, expected 1", name, frame_tick);
                end
                bcd_in = bcd_mid;
                advance_to(3);
                checks++;
                if (frame_tick !== 1'b0) begin
                    errors++;
                    $display("FAIL %s frame_tick_width: got %b, expected 0", name, frame_tick);
                end
            end
        end
        advance_to(16);
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (an !== 4'b1111 || seg !== 7'h00 || dp !== 1'b0 || frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL %s: got an=%b seg=%h dp=%b tick=%b, expected an=1111 seg=00 dp=0 tick=0",
                     name, an, seg, dp, frame_tick);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bcd_in = 16'h1234;
        dp_in = 4'h0;
        blank_lz = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        rst = 1'b0;
        pos = 0;
    endtask

    task automatic test_scan_order();
        run_frame("scan_1234", 16'h1234, 4'h0, 1'b0, 16'h1234);
        run_frame("scan_1234_again", 16'h1234, 4'h0, 1'b0, 16'h1234);
    endtask

    task automatic test_leading_zero();
        run_frame("lz_on_0007", 16'h0007, 4'h0, 1'b1, 16'h0007);
        run_frame("lz_off_0007", 16'h0007, 4'h0, 1'b0, 16'h0007);
        run_frame("lz_on_0000", 16'h0000, 4'h0, 1'b1, 16'h0000);
    endtask

    task automatic test_dash();
        run_frame("dash_0A05", 16'h0A05, 4'h0, 1'b1, 16'h0A05);
        run_frame("dash_FB9C", 16'hFB9C, 4'h0, 1'b1, 16'hFB9C);
    endtask

    task automatic test_dp();
        run_frame("dp_0010", 16'h0000, 4'b0010, 1'b1, 16'h0000);
        run_frame("dp_1001", 16'h8060, 4'b1001, 1'b1, 16'h8060);
    endtask

    task automatic test_back_to_back();
        run_frame("tear_1234", 16'h1234, 4'h0, 1'b0, 16'h5678);
        run_frame("next_5678", 16'h5678, 4'h0, 1'b0, 16'h5678);
    endtask

    task automatic test_reset_mid_frame();
        pos = 0;
        bcd_in = 16'h4321;
        dp_in = 4'hF;
        blank_lz = 1'b0;
        advance_to(9);
        rst = 1'b1;
        step();
        check_reset_outputs("reset_mid_frame");
        rst = 1'b0;
        run_frame("restart_1234", 16'h1234, 4'h0, 1'b0, 16'h1234);
    endtask

    initial begin
        glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
        test_reset();
        test_scan_order();
        test_leading_zero();
        test_dash();
        test_dp();
        test_back_to_back();
        test_reset_mid_frame();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_bcd_seg_scan
`default_nettype wire
